// File: rtl/reset_req_gen.sv
// Watchdog reset requester: countdown, fixed-width reset pulse to an async reset
// controller, then checks that the controller's synchronous reset rose and fell.
module reset_req_gen #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned ACK_TIMEOUT  = 8,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             kick,
    input  logic             force_req,
    input  logic [CNT_W-1:0] timeout_load,
    input  logic             reset_ack,
    output logic             reset_req,
    output logic             busy,
    output logic             fault,
    output logic [1:0]       retry_cnt
);

    localparam int unsigned PC_W = $clog2(PULSE_CYCLES + 1);
    localparam int unsigned AC_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_ASSERT,
        S_WAIT_ACK,
        S_WAIT_REL,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  pulse_q, pulse_d;
    logic [AC_W-1:0]  ackc_q, ackc_d;
    logic             ack_seen_q, ack_seen_d;
    logic [1:0]       retry_q, retry_d;
    logic             req_q, req_d;
    logic             busy_q, busy_d;
    logic             fault_q, fault_d;
    logic             start_pulse;
    logic [CNT_W-1:0] load_val;

    assign load_val = (timeout_load == '0) ? CNT_W'(1) : timeout_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pulse_q    <= '0;
            ackc_q     <= '0;
            ack_seen_q <= 1'b0;
            retry_q    <= '0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pulse_q    <= pulse_d;
            ackc_q     <= ackc_d;
            ack_seen_q <= ack_seen_d;
            retry_q    <= retry_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pulse_d     = pulse_q;
        ackc_d      = ackc_q;
        ack_seen_d  = ack_seen_q;
        retry_d     = retry_q;
        start_pulse = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (force_req) begin
                    start_pulse = 1'b1;
                end else if (enable) begin
                    state_d = S_ARMED;
                    cnt_d   = load_val;
                end
            end
            S_ARMED: begin
                if (force_req) begin
                    start_pulse = 1'b1;
                end else if (!enable) begin
                    state_d = S_IDLE;
                end else if (kick) begin
                    cnt_d = load_val;
                end else if (cnt_q <= CNT_W'(1)) begin
                    cnt_d       = '0;
                    start_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ASSERT: begin
                ack_seen_d = ack_seen_q | reset_ack;
                if (pulse_q == PC_W'(PULSE_CYCLES - 1)) begin
                    state_d = S_WAIT_ACK;
                    ackc_d  = '0;
                end else begin
                    pulse_d = pulse_q + PC_W'(1);
                end
            end
            S_WAIT_ACK: begin
                ack_seen_d = ack_seen_q | reset_ack;
                if (ack_seen_q || reset_ack) begin
                    state_d = S_WAIT_REL;
                end else if (ackc_q == AC_W'(ACK_TIMEOUT - 1)) begin
                    if (retry_q < 2'(MAX_RETRY)) begin
                        retry_d     = retry_q + 2'd1;
                        start_pulse = 1'b1;
                    end else begin
                        state_d = S_FAULT;
                    end
                end else begin
                    ackc_d = ackc_q + AC_W'(1);
                end
            end
            S_WAIT_REL: begin
                if (!reset_ack) begin
                    retry_d = '0;
                    if (enable) begin
                        state_d = S_ARMED;
                        cnt_d   = load_val;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_FAULT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    retry_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every route into ASSERT restarts the pulse width and forgets earlier acks.
        if (start_pulse) begin
            state_d    = S_ASSERT;
            pulse_d    = '0;
            ack_seen_d = 1'b0;
        end

        req_d   = (state_d == S_ASSERT);
        busy_d  = (state_d == S_ASSERT) || (state_d == S_WAIT_ACK) || (state_d == S_WAIT_REL);
        fault_d = (state_d == S_FAULT);
    end

    assign reset_req = req_q;
    assign busy      = busy_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_reset_req_gen.sv
// Directed bench for reset_req_gen: a per-cycle vector table plus hand-written
// sequences for kick boundary, missing ack, mid-pulse reset and enable drop.
module tb_reset_req_gen;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        kick;
    logic        force_req;
    logic [15:0] timeout_load;
    logic        reset_ack;
    logic        reset_req;
    logic        busy;
    logic        fault;
    logic [1:0]  retry_cnt;

    int unsigned n_cmp;
    int unsigned n_err;

    // Expected output word: {reset_req, busy, fault, retry_cnt[1:0]}
    localparam logic [4:0] E_OFF   = 5'b00000;
    localparam logic [4:0] E_PULSE = 5'b11000;
    localparam logic [4:0] E_WAIT  = 5'b01000;

    typedef struct {
        logic        en;
        logic        kk;
        logic        fr;
        logic [15:0] ld;
        logic        ack;
        logic [4:0]  exp;
    } vec_t;

    vec_t vecs[21];

    reset_req_gen #(
        .CNT_W(16),
        .PULSE_CYCLES(4),
        .ACK_TIMEOUT(8),
        .MAX_RETRY(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .kick(kick),
        .force_req(force_req),
        .timeout_load(timeout_load),
        .reset_ack(reset_ack),
        .reset_req(reset_req),
        .busy(busy),
        .fault(fault),
        .retry_cnt(retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic en, input logic kk, input logic fr,
                                input logic [15:0] ld, input logic ack, input logic [4:0] exp);
        vec_t v;
        v.en  = en;
        v.kk  = kk;
        v.fr  = fr;
        v.ld  = ld;
        v.ack = ack;
        v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {reset_req, busy, fault, retry_cnt};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got req=%b busy=%b fault=%b retry=%0d, expected req=%b busy=%b fault=%b retry=%0d",
                     name, $time, act[4], act[3], act[2], act[1:0], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    // Drive on the falling edge, let the DUT sample on the rising edge, look 1 ns later.
    task automatic step(input logic en, input logic kk, input logic fr,
                        input logic [15:0] ld, input logic ack);
        @(negedge clk);
        enable       = en;
        kick         = kk;
        force_req    = fr;
        timeout_load = ld;
        reset_ack    = ack;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [4:0] e;
        n_cmp = 0;
        n_err = 0;

        // Expiry with load 5 and an ack lasting three cycles, then a forced pulse from IDLE.
        vecs[0]  = mk(1, 0, 0, 16'd5, 0, E_OFF);
        vecs[1]  = mk(1, 0, 0, 16'd5, 0, E_OFF);
        vecs[2]  = mk(1, 0, 0, 16'd5, 0, E_OFF);
        vecs[3]  = mk(1, 0, 0, 16'd5, 0, E_OFF);
        vecs[4]  = mk(1, 0, 0, 16'd5, 0, E_OFF);
        vecs[5]  = mk(1, 0, 0, 16'd5, 0, E_PULSE);
        vecs[6]  = mk(1, 0, 0, 16'd5, 0, E_PULSE);
        vecs[7]  = mk(1, 0, 0, 16'd5, 1, E_PULSE);
        vecs[8]  = mk(1, 0, 0, 16'd5, 1, E_PULSE);
        vecs[9]  = mk(1, 0, 0, 16'd5, 1, E_WAIT);
        vecs[10] = mk(1, 0, 0, 16'd5, 0, E_WAIT);
        vecs[11] = mk(1, 0, 0, 16'd5, 0, E_OFF);
        vecs[12] = mk(0, 0, 0, 16'd5, 0, E_OFF);
        vecs[13] = mk(0, 0, 1, 16'd5, 0, E_PULSE);
        vecs[14] = mk(0, 0, 0, 16'd5, 0, E_PULSE);
        vecs[15] = mk(0, 0, 0, 16'd5, 1, E_PULSE);
        vecs[16] = mk(0, 0, 0, 16'd5, 0, E_PULSE);
        vecs[17] = mk(0, 0, 0, 16'd5, 0, E_WAIT);
        vecs[18] = mk(0, 0, 0, 16'd5, 0, E_WAIT);
        vecs[19] = mk(0, 0, 0, 16'd5, 0, E_OFF);
        vecs[20] = mk(0, 0, 0, 16'd5, 0, E_OFF);

        rst_n        = 1'b0;
        enable       = 1'b0;
        kick         = 1'b0;
        force_req    = 1'b0;
        timeout_load = '0;
        reset_ack    = 1'b0;
        #12;
        chk("reset_state", E_OFF);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].en, vecs[i].kk, vecs[i].fr, vecs[i].ld, vecs[i].ack);
            chk($sformatf("table[%0d]", i), vecs[i].exp);
        end

        // Regular kicks with load 3 keep the watchdog quiet.
        step(1, 0, 0, 16'd3, 0);
        chk("kick_arm", E_OFF);
        for (int i = 0; i < 20; i++) begin
            step(1, logic'(i % 2), 0, 16'd3, 0);
            chk($sformatf("kick_loop[%0d]", i), E_OFF);
        end
        step(1, 0, 0, 16'd3, 0);
        chk("kick_cnt2", E_OFF);
        step(1, 0, 0, 16'd3, 0);
        chk("kick_cnt1", E_OFF);
        step(1, 1, 0, 16'd3, 0);
        chk("kick_at_expiry", E_OFF);
        step(1, 0, 0, 16'd3, 0);
        chk("kick_reload_a", E_OFF);
        step(1, 0, 0, 16'd3, 0);
        chk("kick_reload_b", E_OFF);
        step(1, 0, 0, 16'd3, 0);
        chk("kick_reload_expiry", E_PULSE);

        // Enable drops during the pulse: pulse still completes, ack, then IDLE.
        step(0, 0, 0, 16'd3, 0);
        chk("endrop_p2", E_PULSE);
        step(0, 0, 0, 16'd3, 0);
        chk("endrop_p3", E_PULSE);
        step(0, 0, 0, 16'd3, 1);
        chk("endrop_p4", E_PULSE);
        step(0, 0, 0, 16'd3, 0);
        chk("endrop_wait_ack", E_WAIT);
        step(0, 0, 0, 16'd3, 0);
        chk("endrop_wait_rel", E_WAIT);
        step(0, 0, 0, 16'd3, 0);
        chk("endrop_idle", E_OFF);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 16'd3, 0);
            chk($sformatf("endrop_quiet[%0d]", i), E_OFF);
        end

        // Missing ack: four pulses 12 cycles apart, retries 0..3, then sticky fault.
        step(1, 0, 1, 16'd3, 0);
        chk("noack[0]", E_PULSE);
        for (int k = 1; k < 52; k++) begin
            step(1, 0, 0, 16'd3, 0);
            if (k < 48) begin
                e = {((k % 12) < 4) ? 1'b1 : 1'b0, 1'b1, 1'b0, 2'(k / 12)};
            end else begin
                e = 5'b00111;
            end
            chk($sformatf("noack[%0d]", k), e);
        end
        step(1, 1, 1, 16'd3, 0);
        chk("fault_ignores_force_kick", 5'b00111);
        step(1, 0, 0, 16'd3, 0);
        chk("fault_sticky", 5'b00111);
        step(0, 0, 0, 16'd3, 0);
        chk("fault_clear", E_OFF);

        // Power-on reset in the second pulse cycle kills the pulse at once.
        step(0, 0, 1, 16'd3, 0);
        chk("rstmid_p1", E_PULSE);
        step(0, 0, 0, 16'd3, 0);
        chk("rstmid_p2", E_PULSE);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_async", E_OFF);
        step(0, 0, 0, 16'd3, 0);
        chk("rstmid_held", E_OFF);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 16'd3, 0);
            chk($sformatf("rstmid_after[%0d]", i), E_OFF);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
